// File: rtl/event_player.sv
// event_player: replays queued timed events as one-cycle value strobes on two streams
module event_player #(
  parameter int DEPTH = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          abort,
  input  logic          ev_valid,
  output logic          ev_ready,
  input  logic [31:0]   ev_delay,
  input  logic [1:0]    ev_mask,
  input  logic [DW-1:0] ev_data0,
  input  logic [DW-1:0] ev_data1,
  output logic [DW-1:0] input_0,
  output logic          new_input_0,
  output logic [DW-1:0] input_1,
  output logic          new_input_1,
  output logic          busy,
  output logic          done,
  output logic [15:0]   ev_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] mem_delay [DEPTH];
  logic [1:0] mem_mask [DEPTH];
  logic [DW-1:0] mem_d0 [DEPTH];
  logic [DW-1:0] mem_d1 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic [31:0] cnt, cur_delay;
  logic [1:0] cur_mask;
  logic [DW-1:0] cur_d0, cur_d1;
  logic full, empty, push, pop, fire, inc;
  assign full = occ == (AW+1)'(DEPTH);
  assign empty = occ == '0;
  assign ev_ready = !full;
  assign push = ev_valid && !full;
  assign busy = state == WAIT;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    fire = 1'b0;
    inc = 1'b0;
    if (en) begin
      if (abort && state != IDLE) state_n = IDLE;
      else if (state == WAIT) begin
        fire = cnt == cur_delay;
        inc = !fire;
        pop = fire && !empty;
        state_n = fire && empty ? DONE : WAIT;
      end else if (start) begin
        pop = !empty;
        state_n = empty ? DONE : WAIT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_delay[wr_ptr] <= ev_delay;
      mem_mask[wr_ptr] <= ev_mask;
      mem_d0[wr_ptr] <= ev_data0;
      mem_d1[wr_ptr] <= ev_data1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      cnt <= '0;
      ev_count <= '0;
      cur_delay <= '0;
      cur_mask <= '0;
      cur_d0 <= '0;
      cur_d1 <= '0;
      new_input_0 <= 1'b0;
      new_input_1 <= 1'b0;
      input_0 <= '0;
      input_1 <= '0;
    end else begin
      state <= state_n;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      cnt <= pop ? '0 : inc ? cnt + 32'd1 : cnt;
      if (pop) begin
        cur_delay <= mem_delay[rd_ptr];
        cur_mask <= mem_mask[rd_ptr];
        cur_d0 <= mem_d0[rd_ptr];
        cur_d1 <= mem_d1[rd_ptr];
      end
      new_input_0 <= fire && cur_mask[0];
      new_input_1 <= fire && cur_mask[1];
      input_0 <= fire && cur_mask[0] ? cur_d0 : '0;
      input_1 <= fire && cur_mask[1] ? cur_d1 : '0;
      ev_count <= ev_count + 16'(fire);
    end
  end
endmodule

// File: doc/event_player.md
EVENT_PLAYER -- requirements
Module: event_player

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO depth in entries; power of two, minimum 2.
REQ-002 Parameter DW, default 64, width of each input stream value.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable.
- start  in  1  one-cycle request to begin playback.
- abort  in  1  one-cycle request to stop playback.
- ev_valid  in  1  load-side event valid.
- ev_ready  out  1  load-side ready.
- ev_delay  in  32  cycles to wait after the previous reference edge.
- ev_mask  in  2  bit x set means stream x carries a value in this event.
- ev_data0  in  DW  value for stream 0.
- ev_data1  in  DW  value for stream 1.
- input_0  out  DW  stream 0 value to the monitor.
- new_input_0  out  1  stream 0 value strobe.
- input_1  out  DW  stream 1 value to the monitor.
- new_input_1  out  1  stream 1 value strobe.
- busy  out  1  playback in progress.
- done  out  1  playback finished because the FIFO drained.
- ev_count  out  16  number of events fired.

Function
REQ-004 Load handshake: a push occurs on an edge where ev_valid=1 and ev_ready=1.
- ev_ready = !full, combinational.
- A pushed event stores {delay, mask, data0, data1} in order.
- Loading is allowed in every state and is independent of en.
REQ-005 The FIFO holds DEPTH entries.
- Pointers wrap modulo DEPTH.
- full/empty come from an occupancy counter of width log2(DEPTH)+1.
REQ-006 FSM states: IDLE, WAIT, DONE.
- busy = (state==WAIT).
- done = (state==DONE).
REQ-007 IDLE, with start=1 and en=1:
- FIFO non-empty: pop the head into the current-event register, set cnt=0, go to WAIT.
- FIFO empty: go to DONE.
REQ-008 WAIT, on each en=1 edge:
- If cnt != cur_delay: cnt increments by 1.
- If cnt == cur_delay: fire.
REQ-009 Fire, on the firing edge:
- Register new_input_x = cur_mask[x].
- Register input_x = cur_data_x where cur_mask[x]=1, else 0.
- ev_count increments by 1, wrapping from 0xFFFF to 0.
- FIFO non-empty: pop the next event, set cnt=0, stay in WAIT.
- FIFO empty: go to DONE.
REQ-010 Timing: the strobe is visible for exactly one cycle, starting D+1 edges after the start edge (first event) or after the previous firing edge (later events).
- D=0 therefore produces strobes on consecutive cycles.
REQ-011 Outside a fire cycle, new_input_0 and new_input_1 are 0 and input_0 and input_1 are 0.
REQ-012 en=0 freezes the FSM, cnt, ev_count and the FIFO read side.
- The strobes and data outputs are 0 while en=0.
- A fire pending at an en=0 edge is deferred to the next en=1 edge.
REQ-013 abort=1 on an edge, in WAIT or DONE:
- Go to IDLE.
- Discard the current event without firing it.
- Leave the remaining FIFO contents intact.
- abort takes priority over a fire on the same edge.
REQ-014 start=1 in DONE: go to IDLE-equivalent behaviour, i.e. pop if non-empty, else stay in DONE.
- start is ignored in WAIT.
REQ-015 A push on the same edge as a pop at full is impossible (ev_ready=0).
- A push and a pop on the same edge at partial occupancy leave occupancy unchanged.
- An event pushed on the firing edge into an empty FIFO is not popped on that edge.
- The FSM goes to DONE in that case.
REQ-016 cnt and ev_delay are 32 bits unsigned; equality comparison only, with no overflow path.

Reset
REQ-017 On an rst=1 edge, regardless of en:
- state = IDLE, FIFO emptied, cnt = 0, ev_count = 0.
- All outputs are 0, except ev_ready = 1 on the cycle after reset.
REQ-018 rst mid-playback discards all queued events; no strobe is produced on or after the reset edge.

Verification
REQ-019 Push {D=3, mask=11, 1, 1}, then start -> both strobes high for one cycle, 4 edges after start; input_0=1, input_1=1; ev_count=1; done=1 on the next cycle.
REQ-020 Push {0,11,11,5} and {0,01,100,200}, then start -> strobes on 2 consecutive cycles; the second has new_input_1=0, input_1=0, input_0=100.
REQ-021 Push DEPTH events -> ev_ready=0; an extra ev_valid is not accepted; playback fires exactly DEPTH events.
REQ-022 D=5 with en held low 3 cycles mid-wait -> the strobe is delayed by exactly 3 cycles and all outputs are 0 while en=0.
REQ-023 abort at cnt=2 of D=4 -> no strobe; state IDLE; the next start plays the next queued event.
REQ-024 rst during WAIT with 3 events queued -> no strobe; ev_count=0; FIFO empty; start then gives done=1.
